// File: rtl/rom_loader_pkg.sv
// Shared types and default sizing for the ROM-to-matrix-bank loader.
//   state_t      : loader FSM states
//   DATA_WIDTH   : ROM word / bank byte width
//   BANK_DEPTH   : bytes per row (width of the one-hot select)
//   ADDR_WIDTH   : ROM address width
//   DRAIN_CYCLES : cycles spent after the last read so the write pipe empties
package rom_loader_pkg;

   localparam int DATA_WIDTH   = 8;
   localparam int BANK_DEPTH   = 8;
   localparam int ADDR_WIDTH   = 8;
   localparam int DRAIN_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/onehot_select_dec.sv
// Binary byte index to one-hot bank select.
//   k           in  binary byte index
//   en          in  decode enable; select is all-zero when low
//   select_line out one-hot select, bit k set when en=1
module onehot_select_dec #(
   parameter int BANK_DEPTH = rom_loader_pkg::BANK_DEPTH,
   parameter int K_WIDTH    = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
   input  logic [K_WIDTH-1:0]    k,
   input  logic                  en,
   output logic [BANK_DEPTH-1:0] select_line
);

   always_comb begin
      select_line = '0;
      if (en) begin
         select_line[k] = 1'b1;
      end
   end

endmodule

// File: rtl/rom_matrix_loader.sv
// Loads NUM_ROWS rows of BANK_DEPTH bytes from a synchronous ROM into the
// systolic-array matrix bank, handing each completed row downstream.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : begin a load (IDLE only); base_addr sampled with it
//   rom_en/addr  : ROM read strobe and address; rom_data returns next cycle
//   enable, select_line, data_in : registered bank write port
//   row_valid    : bank holds a complete row; cleared by row_consume
//   busy         : loader not idle
//   done         : one-cycle pulse after the last row is consumed
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one ROM read per cycle for bytes 0..BANK_DEPTH-1
// DRAIN | no reads; last writes retire through the two-stage write pipe
// HOLD  | row complete, row_valid=1, waiting for row_consume
module rom_matrix_loader #(
   parameter int DATA_WIDTH = rom_loader_pkg::DATA_WIDTH,
   parameter int BANK_DEPTH = rom_loader_pkg::BANK_DEPTH,
   parameter int ADDR_WIDTH = rom_loader_pkg::ADDR_WIDTH,
   parameter int NUM_ROWS   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  enable,
   output logic [BANK_DEPTH-1:0] select_line,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  row_valid,
   input  logic                  row_consume,
   output logic                  busy,
   output logic                  done
);

   import rom_loader_pkg::*;

   localparam int K_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [K_W-1:0]        k_q, k_d;
   logic [DRAIN_W-1:0]    drain_q, drain_d;
   logic                  done_q, done_d;

   // write pipe: stage 1 tracks the read in flight, stage 2 is the bank port
   logic                  rd_en_q, rd_en_d;
   logic [K_W-1:0]        rd_k_q, rd_k_d;
   logic                  enable_q, enable_d;
   logic [BANK_DEPTH-1:0] select_q, select_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [BANK_DEPTH-1:0] sel_dec;

   onehot_select_dec #(
      .BANK_DEPTH (BANK_DEPTH),
      .K_WIDTH    (K_W)
   ) u_sel_dec (
      .k           (rd_k_q),
      .en          (rd_en_q),
      .select_line (sel_dec)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         row_q    <= '0;
         k_q      <= '0;
         drain_q  <= '0;
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_k_q   <= '0;
         enable_q <= 1'b0;
         select_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         row_q    <= row_d;
         k_q      <= k_d;
         drain_q  <= drain_d;
         done_q   <= done_d;
         rd_en_q  <= rd_en_d;
         rd_k_q   <= rd_k_d;
         enable_q <= enable_d;
         select_q <= select_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      row_d   = row_q;
      k_d     = k_q;
      drain_d = drain_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = base_addr;
               row_d   = '0;
               k_d     = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (k_q == K_W'(BANK_DEPTH - 1)) begin
               k_d     = '0;
               drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
               state_d = DRAIN;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               state_d = HOLD;
            end else begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         HOLD: begin
            // start is deliberately not looked at here: consume always wins
            if (row_consume) begin
               if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  k_d     = '0;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en_d  = rom_en;
      rd_k_d   = k_q;
      enable_d = rd_en_q;
      select_d = sel_dec;
      data_d   = rd_en_q ? rom_data : data_q;
   end

   // address wraps modulo 2^ADDR_WIDTH by construction
   assign rom_en      = (state_q == FETCH);
   assign rom_addr    = rom_en ? (base_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(BANK_DEPTH)
                                 + ADDR_WIDTH'(k_q)) : '0;
   assign enable      = enable_q;
   assign select_line = select_q;
   assign data_in     = data_q;
   assign row_valid   = (state_q == HOLD);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

endmodule

// File: tb/tb_rom_matrix_loader.sv
module tb_rom_matrix_loader;

   localparam int NR = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       row_consume = 1'b0;
   logic [7:0] base_addr = 8'h00;
   logic [7:0] rom_data = 8'h00;
   logic       rom_en, enable, row_valid, busy, done;
   logic [7:0] rom_addr, data_in, select_line;

   logic [7:0] mem [256];
   int nvec = 0;
   int nerr = 0;

   // transaction-level model: a run is (base, row, cycle its fetch began)
   bit m_active = 0;
   bit m_done = 0;
   int m_row = 0;
   int m_f = 0;
   int m_base = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   rom_matrix_loader #(
      .DATA_WIDTH (8),
      .BANK_DEPTH (8),
      .ADDR_WIDTH (8),
      .NUM_ROWS   (NR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .enable      (enable),
      .select_line (select_line),
      .data_in     (data_in),
      .row_valid   (row_valid),
      .row_consume (row_consume),
      .busy        (busy),
      .done        (done)
   );

   always @(posedge clk) begin
      if (rom_en) rom_data <= mem[rom_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // per-cycle comparison against the run timeline:
   // reads at offsets 0..7, writes at 2..9, row held from offset 10
   always @(negedge clk) begin : cmp
      int j;
      bit e_ren, e_en, e_rv;
      j     = cyc - m_f;
      e_ren = m_active && (j >= 0) && (j < 8);
      e_en  = m_active && (j >= 2) && (j < 10);
      e_rv  = m_active && (j >= 10);
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("row_valid", 32'(row_valid), 32'(e_rv));
      chk("rom_en", 32'(rom_en), 32'(e_ren));
      chk("enable", 32'(enable), 32'(e_en));
      chk("select_line", 32'(select_line), e_en ? (32'd1 << (j - 2)) : 32'd0);
      if (e_ren) chk("rom_addr", 32'(rom_addr), 32'((m_base + m_row * 8 + j) & 255));
      if (e_en) chk("data_in", 32'(data_in), 32'(mem[(m_base + m_row * 8 + j - 2) & 255]));
   end

   task automatic advance();
      bit rv;
      rv     = m_active && ((cyc - m_f) >= 10);
      m_done = 0;
      if (reset) begin
         if (!m_active) begin
            if (start) begin
               m_active = 1;
               m_row    = 0;
               m_base   = int'(base_addr);
               m_f      = cyc + 1;
            end
         end else if (rv && row_consume) begin
            if (m_row == NR - 1) begin
               m_active = 0;
               m_done   = 1;
            end else begin
               m_row++;
               m_f = cyc + 1;
            end
         end
      end
      cyc++;
   endtask

   task automatic tick(input bit s, input bit c, input logic [7:0] b);
      @(posedge clk);
      advance();
      #1;
      start       = s;
      row_consume = c;
      base_addr   = b;
   endtask

   // asserts reset mid-cycle, checks outputs clear immediately, releases later
   task automatic hit_reset();
      #2;
      reset       = 1'b0;
      start       = 1'b0;
      row_consume = 1'b0;
      m_active    = 0;
      m_done      = 0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rom_en", 32'(rom_en), 32'd0);
      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_select", 32'(select_line), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_row_valid", 32'(row_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      tick(0, 0, 8'h00);
      tick(0, 0, 8'h00);
      #2;
      reset = 1'b1;
   endtask

   initial begin : main
      logic [7:0] seq [8];
      int n_en;
      seq = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
      for (int a = 0; a < 256; a++) mem[a] = 8'(a);
      #12 reset = 1'b1;

      // two-row load at 0x10, start in the done cycle, reset on 4th write
      for (int t = 0; t <= 39; t++) begin
         tick(t == 0 || t == 33, t == 16 || t == 32, (t < 33) ? 8'h10 : 8'h40);
         case (t)
            1: begin
               chk("a_rom_en_c1", 32'(rom_en), 32'd1);
               chk("a_rom_addr_c1", 32'(rom_addr), 32'h10);
            end
            2: chk("a_enable_c2", 32'(enable), 32'd0);
            3: begin
               chk("a_enable_c3", 32'(enable), 32'd1);
               chk("a_select_c3", 32'(select_line), 32'h01);
               chk("a_data_c3", 32'(data_in), 32'h10);
            end
            10: begin
               chk("a_select_c10", 32'(select_line), 32'h80);
               chk("a_data_c10", 32'(data_in), 32'h17);
            end
            11: begin
               chk("a_row_valid_c11", 32'(row_valid), 32'd1);
               chk("a_enable_c11", 32'(enable), 32'd0);
            end
            16: chk("a_row_valid_c16", 32'(row_valid), 32'd1);
            17: begin
               chk("a_row_valid_c17", 32'(row_valid), 32'd0);
               chk("a_rom_addr_c17", 32'(rom_addr), 32'h18);
            end
            24: chk("a_rom_addr_c24", 32'(rom_addr), 32'h1F);
            32: chk("a_busy_c32", 32'(busy), 32'd1);
            33: begin
               chk("a_done_c33", 32'(done), 32'd1);
               chk("a_busy_c33", 32'(busy), 32'd0);
            end
            34: begin
               chk("a_done_c34", 32'(done), 32'd0);
               chk("a_rom_en_c34", 32'(rom_en), 32'd1);
               chk("a_rom_addr_c34", 32'(rom_addr), 32'h40);
            end
            39: begin
               chk("a_enable_c39", 32'(enable), 32'd1);
               chk("a_select_c39", 32'(select_line), 32'h08);
               chk("a_data_c39", 32'(data_in), 32'h43);
            end
            default: ;
         endcase
      end
      hit_reset();
      n_en = 0;
      for (int t = 0; t < 12; t++) begin
         tick(0, 0, 8'h00);
         n_en += int'(enable);
      end
      chk("a_no_enable_after_reset", 32'(n_en), 32'd0);
      chk("a_idle_after_reset", 32'(busy), 32'd0);

      // wrap at 0xFC; stray start/consume in FETCH and HOLD
      for (int t = 0; t <= 26; t++) begin
         tick(t == 0 || t == 3 || t == 12 || t == 13, t == 4 || t == 13 || t == 24,
              (t == 0) ? 8'hFC : 8'h55);
         if (t >= 1 && t <= 8) chk("b_rom_addr_wrap", 32'(rom_addr), 32'(seq[t-1]));
         case (t)
            11: chk("b_row_valid_c11", 32'(row_valid), 32'd1);
            13: chk("b_row_valid_c13", 32'(row_valid), 32'd1);
            14: begin
               chk("b_row_valid_c14", 32'(row_valid), 32'd0);
               chk("b_rom_addr_c14", 32'(rom_addr), 32'h04);
            end
            24: chk("b_row_valid_c24", 32'(row_valid), 32'd1);
            25: chk("b_done_c25", 32'(done), 32'd1);
            26: begin
               chk("b_done_c26", 32'(done), 32'd0);
               chk("b_busy_c26", 32'(busy), 32'd0);
            end
            default: ;
         endcase
      end

      // randomized traffic against the model
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      for (int t = 0; t < 4000; t++) begin
         if ($urandom_range(0, 299) == 0) begin
            hit_reset();
         end else begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
         end
      end
      tick(0, 0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
